// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute unit: op codes, FSM states,
// shift-amount width and a small op classification helper.
package alu_pkg;

  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_EQ    = 4'b1000;
  localparam logic [3:0] ALU_NE    = 4'b1001;
  localparam logic [3:0] ALU_GE    = 4'b1010;
  localparam logic [3:0] ALU_LT    = 4'b1100;
  localparam logic [3:0] ALU_FORCE = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  // Shifts go through the iterative shifter; everything else is one cycle.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops. Shift codes and undefined codes yield 0
// here; shifts are handled by the iterative shifter in the parent.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result
);

  // Select the single-cycle result; compares drive bit 0 only.
  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_AND:   o_result = i_a & i_b;
      ALU_OR:    o_result = i_a | i_b;
      ALU_ADD:   o_result = i_a + i_b;
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_EQ:    o_result[0] = (i_a == i_b);
      ALU_NE:    o_result[0] = (i_a != i_b);
      ALU_GE:    o_result[0] = ($signed(i_a) >= $signed(i_b));
      ALU_LT:    o_result[0] = ($signed(i_a) < $signed(i_b));
      ALU_FORCE: o_result[0] = 1'b1;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle execute unit: one-cycle logic/arithmetic via alu_core, shifts
// iterated one bit per cycle, results held until the downstream handshake.
//
//   state    | meaning
//   IDLE     | ready to accept an operation
//   SHIFT    | iterative shift in progress, counter holds remaining bits
//   DONE     | result valid, waiting for out_ready
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);

  alu_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_work;
  logic [SHAMT_W-1:0]    r_cnt;
  logic [3:0]            r_op;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_out_valid;

  logic [DATA_WIDTH-1:0] w_core_result;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [SHAMT_W-1:0]    w_shamt;

  assign w_shamt = SrcB[SHAMT_W-1:0];

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .i_op    (Operation),
    .i_a     (SrcA),
    .i_b     (SrcB),
    .o_result(w_core_result)
  );

  // One-bit step of the latched shift; SRA keeps the original sign bit.
  always_comb begin
    w_shift_next = r_work;
    case (r_op)
      ALU_SLL: w_shift_next = {r_work[DATA_WIDTH-2:0], 1'b0};
      ALU_SRL: w_shift_next = {1'b0, r_work[DATA_WIDTH-1:1]};
      ALU_SRA: w_shift_next = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
      default: w_shift_next = r_work;
    endcase
  end

  // Ready is gated by reset so upstream never sees an accept while reset holds.
  assign in_ready  = (r_state == ST_IDLE) && !reset;
  assign out_valid = r_out_valid;
  assign ALUResult = r_result;
  assign Zero      = r_zero;

  // Control FSM with registered result, zero flag and valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_op        <= ALU_AND;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_shift(Operation)) begin
              if (w_shamt == '0) begin
                r_result    <= SrcA;
                r_zero      <= (SrcA == '0);
                r_out_valid <= 1'b1;
                r_state     <= ST_DONE;
              end else begin
                r_work  <= SrcA;
                r_op    <= Operation;
                r_cnt   <= w_shamt;
                r_state <= ST_SHIFT;
              end
            end else begin
              r_result    <= w_core_result;
              r_zero      <= (w_core_result == '0);
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          r_work <= w_shift_next;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == SHAMT_W'(1)) begin
            r_result    <= w_shift_next;
            r_zero      <= (w_shift_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit with hand-computed expected results.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq_unit #(
    .DATA_WIDTH   (32),
    .OPCODE_LENGTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Operation(Operation),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUResult(ALUResult),
    .Zero     (Zero)
  );

  always #5 clk = ~clk;

  // Count a comparison and report it if observed differs from expected.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready high, check latency/result/zero and handshake.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int cycles;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    #1;
    chk({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    SrcA      = ~a;
    SrcB      = 32'h0000_001F;
    Operation = 4'b0010;
    cycles    = 1;
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk({tag, " latency"}, cycles, exp_lat);
    chk({tag, " result"}, ALUResult, exp);
    chk({tag, " zero"}, Zero, (exp == 32'h0) ? 1 : 0);
    @(posedge clk); #1;
    chk({tag, " post out_valid"}, out_valid, 0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Operation = 4'b0000;
    SrcA      = '0;
    SrcB      = '0;
    #1;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst result", ALUResult, 0);
    chk("rst zero", Zero, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("release in_ready", in_ready, 1);

    run_op("add",   4'b0010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1);
    run_op("sub",   4'b0110, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1);
    run_op("eq",    4'b1000, 32'h0000_0007, 32'h0000_0007, 32'h0000_0001, 1);
    run_op("ne",    4'b1001, 32'h0000_0003, 32'h0000_0004, 32'h0000_0001, 1);
    run_op("lt",    4'b1100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
    run_op("ge",    4'b1010, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1);
    run_op("force", 4'b1101, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1);
    run_op("and",   4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
    run_op("or",    4'b0001, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 1);
    run_op("xor",   4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
    run_op("addwrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1);
    run_op("undef", 4'b1110, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1);
    run_op("sra4",  4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5);
    run_op("sra_pos", 4'b0111, 32'h4000_0000, 32'h0000_0002, 32'h1000_0000, 3);
    run_op("sll0",  4'b0100, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1);
    run_op("sll3",  4'b0100, 32'h8000_0001, 32'h0000_0003, 32'h0000_0008, 4);
    run_op("srl31", 4'b0101, 32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0001, 32);

    // Backpressure: hold out_ready low in DONE and offer a competing op.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    Operation = 4'b0010;
    SrcA      = 32'h0000_0010;
    SrcB      = 32'h0000_0020;
    @(posedge clk); #1;
    Operation = 4'b0011;
    SrcA      = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      chk("bp out_valid", out_valid, 1);
      chk("bp result", ALUResult, 32'h0000_0030);
      chk("bp in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp drain out_valid", out_valid, 0);
    chk("bp drain in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("bp single handshake", out_valid, 0);

    // Reset in the middle of a long shift, after a nonzero result is held.
    run_op("force2", 4'b1101, 32'h0, 32'h0, 32'h0000_0001, 1);
    in_valid  = 1'b1;
    Operation = 4'b0100;
    SrcA      = 32'h0000_0001;
    SrcB      = 32'h0000_0014;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst result", ALUResult, 0);
    chk("midrst zero", Zero, 1);
    chk("midrst in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst release in_ready", in_ready, 1);
    run_op("add_after_rst", 4'b0010, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Multi-cycle execute unit directly downstream of the ALU controller. It consumes the 4-bit `Operation` code plus two operands and produces a registered result and zero flag through valid/ready handshakes. Logic and arithmetic ops complete in one cycle; shifts run on an iterative one-bit-per-cycle shifter, trading latency for area. Sits between operand selection (SrcA/SrcB muxes) and the EX/MEM result path / branch-decision logic.

## Interface
- `DATA_WIDTH`, 32, operand/result width.
- `OPCODE_LENGTH`, 4, width of `Operation`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream offers an operation.
- `in_ready`  out  1  unit can accept; high only in IDLE and not in reset.
- `Operation`  in  OPCODE_LENGTH  ALU op code from the controller.
- `SrcA`  in  DATA_WIDTH  operand A.
- `SrcB`  in  DATA_WIDTH  operand B; shift amount is `SrcB[4:0]`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts result.
- `ALUResult`  out  DATA_WIDTH  registered result.
- `Zero`  out  1  registered, `ALUResult == 0`.

## Operation
- Op codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 EQ, 1001 NE, 1010 GE (signed), 1100 LT (signed, serves SLT and BLT), 1101 FORCE (result = 1, used by JAL/halt).
- Compare ops (EQ/NE/GE/LT) produce 1 or 0 in bit 0, upper bits 0.
- Undefined codes (1011, 1110, 1111): result 0, one-cycle path.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
- SRA replicates `SrcA[DATA_WIDTH-1]`; SRL/SLL fill with 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: `in_ready`=1. On `in_valid && in_ready`: non-shift op → compute, register result, go DONE. Shift op with shamt 0 → register `SrcA`, go DONE. Shift op with shamt k>0 → latch `SrcA`, op, counter = k, go SHIFT.
  - SHIFT: each cycle shift working register one bit, decrement counter; on the cycle counter goes 1→0, register result into `ALUResult`, go DONE. `in_ready`=0.
  - DONE: `out_valid`=1, `ALUResult`/`Zero` stable. On `out_ready` → IDLE. `in_ready`=0 (no overlap of accept and drain).
- Inputs are sampled only at the accept edge; later changes to `SrcA`/`SrcB`/`Operation` do not affect an in-flight op.
- `out_valid` once high stays high with stable data until handshake.

## Timing
- Accept at edge N → `out_valid` high after edge N+1+k (k = shamt for shifts, else 0). Max latency 32 cycles.
- Earliest next accept: cycle after output handshake (throughput ≤ 1 op per 2 cycles).
- Reset values: state IDLE, `out_valid`=0, `ALUResult`=0, `Zero`=1, counter 0; `in_ready`=0 while `reset` high, 1 on first cycle after release.
- Reset asserted mid-SHIFT or in DONE: op discarded, all outputs to reset values immediately (async).
- `out_ready` held high while in IDLE/SHIFT: no effect.
- `in_valid` high while `in_ready`=0: ignored, not queued.

## Structure
- Shared package `alu_pkg`: op-code localparams (ALU_AND … ALU_FORCE), FSM state enum, shift-amount width (5).
- Sub-module `alu_core`: purely combinational single-cycle ops (all non-shift codes); the FSM, counter, iterative shifter and output registers live in `alu_seq_unit`.

## Test plan
- Reset release, then ADD SrcA=0x00000005 SrcB=0x00000003, `out_ready`=1 → `out_valid` one cycle after accept, `ALUResult`=0x00000008, `Zero`=0; back in IDLE next cycle.
- SUB 7−7 → `ALUResult`=0, `Zero`=1; EQ 7,7 → 1; LT 0xFFFFFFFF,1 → 1; GE 0x80000000,0 → 0; FORCE → 1.
- SRA SrcA=0x80000000 SrcB=4 → `out_valid` exactly 5 cycles after accept, `ALUResult`=0xF8000000; SLL by 0 → 1-cycle, result=SrcA.
- SRL 0xFFFFFFFF by 31 → 32-cycle latency, result 0x00000001; `SrcA` changed during SHIFT has no effect.
- Backpressure: `out_ready`=0 for 10 cycles in DONE → `out_valid`/`ALUResult` stable, `in_ready`=0, new `in_valid` ignored; release → one handshake only.
- Assert `reset` during SHIFT of SLL by 20 → outputs immediately reset values; after release, ADD 1+1 completes normally with result 2.
